// File: rtl/tproc_mem_pkg.sv
// tproc_mem_pkg: shared constants and types for the Tproc local memories.
package tproc_mem_pkg;
   localparam int RDW_WRITE_FIRST = 0;
   localparam int RDW_READ_FIRST  = 1;
   localparam int RDW_NO_CHANGE   = 2;
   localparam int COLL_CNT_W      = 16;
   typedef enum logic {ST_INIT, ST_RUN} init_state_e;
endpackage

// File: rtl/dpram_init_fsm.sv
// dpram_init_fsm: post-reset zero-fill sequencer; its write port is borrowed by port A of the RAM.
module dpram_init_fsm
   import tproc_mem_pkg::*;
#(
   parameter int ADDR_WIDTH    = 4,
   parameter int RAM_DEPTH     = 1 << ADDR_WIDTH,
   parameter int INIT_ON_RESET = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  o_busy,
   output logic                  o_fill_we,
   output logic [ADDR_WIDTH-1:0] o_fill_addr
);
   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(RAM_DEPTH - 1);
   init_state_e r_state, w_next;
   logic [ADDR_WIDTH-1:0] r_ptr;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
         r_ptr   <= '0;
      end else begin
         r_state <= w_next;
         r_ptr   <= (r_state == ST_INIT) ? r_ptr + 1'b1 : '0;
      end
   end
   always_comb w_next = (r_state == ST_INIT && r_ptr == LAST) ? ST_RUN : r_state;
   always_comb begin
      o_busy      = (r_state == ST_INIT);
      o_fill_we   = o_busy;
      o_fill_addr = r_ptr;
   end
endmodule

// File: rtl/true_dpram_be.sv
// true_dpram_be: single-clock true dual-port RAM with byte enables, selectable read-during-write,
// optional output register, zero-fill after reset and a same-address collision monitor.
module true_dpram_be
   import tproc_mem_pkg::*;
#(
   parameter int DATA_WIDTH    = 64,
   parameter int ADDR_WIDTH    = 4,
   parameter int RAM_DEPTH     = 1 << ADDR_WIDTH,
   parameter int BYTE_WIDTH    = 8,
   parameter int RDW_MODE      = 0,
   parameter int OUT_REG       = 0,
   parameter int INIT_ON_RESET = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             en_a,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] we_a,
   input  logic [ADDR_WIDTH-1:0]            addr_a,
   input  logic [DATA_WIDTH-1:0]            data_a,
   output logic [DATA_WIDTH-1:0]            q_a,
   output logic                             vld_a,
   input  logic                             en_b,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] we_b,
   input  logic [ADDR_WIDTH-1:0]            addr_b,
   input  logic [DATA_WIDTH-1:0]            data_b,
   output logic [DATA_WIDTH-1:0]            q_b,
   output logic                             vld_b,
   output logic                             init_busy,
   output logic                             collision,
   output logic [COLL_CNT_W-1:0]            coll_cnt
);
   localparam int NB = DATA_WIDTH / BYTE_WIDTH;

   if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_lanes
      $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
   end
   if (RDW_MODE > 2) begin : g_bad_mode
      $error("RDW_MODE must be 0, 1 or 2");
   end
   if (RAM_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
      $error("RAM_DEPTH exceeds the address space");
   end

   function automatic logic [DATA_WIDTH-1:0] f_merge(input logic [DATA_WIDTH-1:0] old,
                                                     input logic [DATA_WIDTH-1:0] din,
                                                     input logic [NB-1:0] we);
      f_merge = old;
      for (int i = 0; i < NB; i++)
         if (we[i]) f_merge[i*BYTE_WIDTH +: BYTE_WIDTH] = din[i*BYTE_WIDTH +: BYTE_WIDTH];
   endfunction

   logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];
   logic                  w_busy, w_fill_we;
   logic [ADDR_WIDTH-1:0] w_fill_addr, w_addr_pa;
   logic                  w_acc_a, w_acc_b, w_wr_a, w_wr_b, w_coll;
   logic [DATA_WIDTH-1:0] w_old_a, w_old_b, w_fin_a, w_fin_b, w_din_pa;
   logic [NB-1:0]         w_we_pa, w_we_pb;
   logic                  w_v1 [2];
   logic [DATA_WIDTH-1:0] w_rd [2];
   logic                  r_v1 [2];
   logic                  r_v2 [2];
   logic [DATA_WIDTH-1:0] r_d1 [2];
   logic [DATA_WIDTH-1:0] r_d2 [2];
   logic                  r_coll;
   logic [COLL_CNT_W-1:0] r_cnt;

   dpram_init_fsm #(
      .ADDR_WIDTH   (ADDR_WIDTH),
      .RAM_DEPTH    (RAM_DEPTH),
      .INIT_ON_RESET(INIT_ON_RESET)
   ) u_init (
      .clk        (clk),
      .rst        (rst),
      .o_busy     (w_busy),
      .o_fill_we  (w_fill_we),
      .o_fill_addr(w_fill_addr)
   );

   always_comb begin
      w_acc_a   = en_a & ~w_busy & ~rst;
      w_acc_b   = en_b & ~w_busy & ~rst;
      w_wr_a    = w_acc_a & (|we_a);
      w_wr_b    = w_acc_b & (|we_b);
      w_coll    = w_acc_a & w_acc_b & (addr_a == addr_b) & (w_wr_a | w_wr_b);
      w_we_pa   = w_fill_we ? '1 : (w_acc_a ? we_a : '0);
      w_addr_pa = w_fill_we ? w_fill_addr : addr_a;
      w_din_pa  = w_fill_we ? '0 : data_a;
      w_we_pb   = w_acc_b ? we_b : '0;
      w_old_a   = r_mem[addr_a];
      w_old_b   = r_mem[addr_b];
      // final stored word: B lanes first, A lanes override where both write the same address
      w_fin_a   = f_merge((w_wr_b && addr_b == addr_a) ? f_merge(w_old_a, data_b, we_b) : w_old_a,
                          data_a, we_a);
      w_fin_b   = (w_wr_a && addr_a == addr_b) ? f_merge(f_merge(w_old_b, data_b, we_b), data_a, we_a)
                                               : f_merge(w_old_b, data_b, we_b);
      w_rd[0]   = (w_wr_a && RDW_MODE == RDW_WRITE_FIRST) ? w_fin_a : w_old_a;
      w_rd[1]   = (w_wr_b && RDW_MODE == RDW_WRITE_FIRST) ? w_fin_b : w_old_b;
      w_v1[0]   = w_acc_a & ~(w_wr_a && RDW_MODE == RDW_NO_CHANGE);
      w_v1[1]   = w_acc_b & ~(w_wr_b && RDW_MODE == RDW_NO_CHANGE);
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NB; i++) begin
         if (w_we_pb[i]) r_mem[addr_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= data_b[i*BYTE_WIDTH +: BYTE_WIDTH];
         if (w_we_pa[i]) r_mem[w_addr_pa][i*BYTE_WIDTH +: BYTE_WIDTH] <= w_din_pa[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int p = 0; p < 2; p++) begin
            r_v1[p] <= 1'b0;
            r_v2[p] <= 1'b0;
            r_d1[p] <= '0;
            r_d2[p] <= '0;
         end
         r_coll <= 1'b0;
         r_cnt  <= '0;
      end else begin
         for (int p = 0; p < 2; p++) begin
            r_v1[p] <= w_v1[p];
            r_v2[p] <= r_v1[p];
            if (w_v1[p]) r_d1[p] <= w_rd[p];
            if (r_v1[p]) r_d2[p] <= r_d1[p];
         end
         r_coll <= w_coll;
         if (w_coll && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      end
   end

   always_comb begin
      q_a       = (OUT_REG != 0) ? r_d2[0] : r_d1[0];
      q_b       = (OUT_REG != 0) ? r_d2[1] : r_d1[1];
      vld_a     = (OUT_REG != 0) ? r_v2[0] : r_v1[0];
      vld_b     = (OUT_REG != 0) ? r_v2[1] : r_v1[1];
      init_busy = w_busy;
      collision = r_coll;
      coll_cnt  = r_cnt;
   end
endmodule

// File: tb/tb_true_dpram_be.sv
// tb_true_dpram_be: three configurations (write-first, read-first+out reg, no-change) driven in
// lockstep and compared against a word/lane-level reference model of the memory.
module tb_true_dpram_be;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1, en_a = 1'b0, en_b = 1'b0;
   logic [7:0]  we_a = '0, we_b = '0;
   logic [3:0]  addr_a = '0, addr_b = '0;
   logic [63:0] data_a = '0, data_b = '0;
   logic [63:0] q_a [3];
   logic [63:0] q_b [3];
   logic        vld_a [3];
   logic        vld_b [3];
   logic        busy [3];
   logic        coll [3];
   logic [15:0] cnt [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      true_dpram_be #(.RDW_MODE(g), .OUT_REG(g == 1 ? 1 : 0)) u_dut (
         .clk(clk), .rst(rst),
         .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a), .q_a(q_a[g]), .vld_a(vld_a[g]),
         .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b), .q_b(q_b[g]), .vld_b(vld_b[g]),
         .init_busy(busy[g]), .collision(coll[g]), .coll_cnt(cnt[g]));
   end

   // reference model: memory image, fill countdown, per-config result pipelines
   logic [63:0] m_mem [16];
   int          m_fill = 0, m_cnt = 0;
   logic        m_coll = 1'b0;
   logic        m_v1 [3][2];
   logic        m_v2 [3][2];
   logic [63:0] m_d1 [3][2];
   logic [63:0] m_d2 [3][2];
   logic        e_v [3][2];
   logic [63:0] e_q [3][2];
   int          n_pass = 0, n_total = 0;

   function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] din, input logic [7:0] we);
      merge = old;
      for (int i = 0; i < 8; i++) if (we[i]) merge[i*8 +: 8] = din[i*8 +: 8];
   endfunction

   task automatic drive(input logic ea, input logic [7:0] wa, input logic [3:0] aa, input logic [63:0] da,
                        input logic eb, input logic [7:0] wb, input logic [3:0] ab, input logic [63:0] db);
      en_a = ea; we_a = wa; addr_a = aa; data_a = da;
      en_b = eb; we_b = wb; addr_b = ab; data_b = db;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // one clock: advance the model with the inputs seen at the edge, return on the falling edge
   task automatic tick();
      logic        busy_now;
      logic        acc [2];
      logic        wr [2];
      logic [3:0]  ad [2];
      logic [63:0] old [2];
      logic [63:0] fin [2];
      @(posedge clk);
      if (rst) begin
         foreach (m_mem[i]) m_mem[i] = '0;
         m_fill = 16; m_coll = 0; m_cnt = 0;
         for (int k = 0; k < 3; k++) for (int p = 0; p < 2; p++) begin
            m_v1[k][p] = 0; m_v2[k][p] = 0; m_d1[k][p] = '0; m_d2[k][p] = '0;
         end
      end else begin
         busy_now = m_fill > 0;
         acc[0] = en_a && !busy_now; acc[1] = en_b && !busy_now;
         wr[0] = acc[0] && we_a != 0; wr[1] = acc[1] && we_b != 0;
         ad[0] = addr_a; ad[1] = addr_b;
         old[0] = m_mem[addr_a]; old[1] = m_mem[addr_b];
         if (wr[1]) m_mem[addr_b] = merge(m_mem[addr_b], data_b, we_b);
         if (wr[0]) m_mem[addr_a] = merge(m_mem[addr_a], data_a, we_a);
         fin[0] = m_mem[ad[0]]; fin[1] = m_mem[ad[1]];
         m_coll = acc[0] && acc[1] && ad[0] == ad[1] && (wr[0] || wr[1]);
         if (m_coll && m_cnt < 65535) m_cnt++;
         for (int k = 0; k < 3; k++) for (int p = 0; p < 2; p++) begin
            if (m_v1[k][p]) m_d2[k][p] = m_d1[k][p];
            m_v2[k][p] = m_v1[k][p];
            m_v1[k][p] = acc[p] && !(wr[p] && k == 2);
            if (m_v1[k][p]) m_d1[k][p] = (wr[p] && k == 0) ? fin[p] : old[p];
         end
         if (busy_now) m_fill--;
      end
      for (int k = 0; k < 3; k++) for (int p = 0; p < 2; p++) begin
         e_v[k][p] = (k == 1) ? m_v2[k][p] : m_v1[k][p];
         e_q[k][p] = (k == 1) ? m_d2[k][p] : m_d1[k][p];
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      int n;
      rst = 1; idle(); tick(); tick();
      for (int k = 0; k < 3; k++) begin
         n_total++;
         if ({q_a[k], vld_a[k], q_b[k], vld_b[k], coll[k], cnt[k]} !== '0 || busy[k] !== 1'b1)
            $display("FAIL reset dut%0d: q_a=%h v=%b q_b=%h v=%b coll=%b cnt=%0d busy=%b, want zeros busy=1",
                     k, q_a[k], vld_a[k], q_b[k], vld_b[k], coll[k], cnt[k], busy[k]);
         else n_pass++;
      end
      rst = 0; n = 0;
      while (busy[0] === 1'b1 && n < 40) begin tick(); n++; end
      n_total++;
      if (n != 16) $display("FAIL init_len: busy lasted %0d cycles, want 16", n); else n_pass++;
      for (int k = 0; k < 3; k++) begin
         n_total++;
         if (busy[k] !== 1'b0) $display("FAIL init_done dut%0d: busy=%b want 0", k, busy[k]); else n_pass++;
      end
   endtask

   task automatic test_init_reads();
      for (int i = 0; i < 16; i++) begin
         drive(1, 0, 4'(i), '0, 1, 0, 4'(15 - i), '0);
         tick();
         for (int k = 0; k < 3; k += 2) begin
            n_total++;
            if ({q_a[k], vld_a[k], q_b[k], vld_b[k]} !== {64'h0, 1'b1, 64'h0, 1'b1})
               $display("FAIL init_read dut%0d addr%0d: q_a=%h v=%b q_b=%h v=%b, want 0 v=1",
                        k, i, q_a[k], vld_a[k], q_b[k], vld_b[k]);
            else n_pass++;
         end
      end
      idle(); tick(); tick();
   endtask

   task automatic test_byte_lanes();
      drive(1, 8'hFF, 3, 64'h1122334455667788, 0, 0, 0, 0); tick();
      drive(1, 8'h0F, 3, 64'hAAAAAAAAAAAAAAAA, 0, 0, 0, 0); tick();
      n_total++;
      if (q_a[0] !== 64'h11223344AAAAAAAA || vld_a[0] !== 1'b1)
         $display("FAIL lanes_wf: q_a=%h v=%b want 11223344aaaaaaaa v=1", q_a[0], vld_a[0]);
      else n_pass++;
      drive(1, 0, 3, '0, 0, 0, 0, 0); tick();
      for (int k = 0; k < 3; k += 2) begin
         n_total++;
         if (q_a[k] !== 64'h11223344AAAAAAAA || vld_a[k] !== 1'b1)
            $display("FAIL lanes_read dut%0d: q_a=%h v=%b want 11223344aaaaaaaa v=1", k, q_a[k], vld_a[k]);
         else n_pass++;
      end
      idle(); tick();
      n_total++;
      if (q_a[1] !== 64'h11223344AAAAAAAA || vld_a[1] !== 1'b1)
         $display("FAIL lanes_read_reg: q_a=%h v=%b want 11223344aaaaaaaa v=1", q_a[1], vld_a[1]);
      else n_pass++;
      tick();
   endtask

   task automatic test_rdw();
      logic [63:0] prev;
      prev = q_a[2];
      drive(1, 8'hFF, 5, 64'h1, 0, 0, 0, 0); tick();
      drive(1, 8'hFF, 5, 64'h2, 0, 0, 0, 0); tick();
      n_total++;
      if (q_a[0] !== 64'h2 || vld_a[0] !== 1'b1)
         $display("FAIL rdw_mode0: q_a=%h v=%b want 2 v=1", q_a[0], vld_a[0]);
      else n_pass++;
      n_total++;
      if (q_a[2] !== prev || vld_a[2] !== 1'b0)
         $display("FAIL rdw_mode2: q_a=%h v=%b want %h v=0", q_a[2], vld_a[2], prev);
      else n_pass++;
      idle(); tick();
      n_total++;
      if (q_a[1] !== 64'h1 || vld_a[1] !== 1'b1)
         $display("FAIL rdw_mode1: q_a=%h v=%b want 1 v=1", q_a[1], vld_a[1]);
      else n_pass++;
      tick();
   endtask

   task automatic test_collision();
      drive(1, 8'hFF, 7, '1, 1, 8'hFF, 7, '0); tick();
      n_total++;
      if (coll[0] !== 1'b1 || cnt[0] !== 16'd1)
         $display("FAIL coll1: coll=%b cnt=%0d want 1 1", coll[0], cnt[0]);
      else n_pass++;
      drive(1, 0, 7, '0, 0, 0, 0, 0); tick();
      n_total++;
      if (coll[0] !== 1'b0 || q_a[0] !== '1)
         $display("FAIL coll1_data: coll=%b q_a=%h want 0 ffffffffffffffff", coll[0], q_a[0]);
      else n_pass++;
      drive(1, 8'h0F, 7, '0, 1, 0, 7, '0); tick();
      n_total++;
      if (q_b[0] !== '1 || vld_b[0] !== 1'b1 || q_a[0] !== 64'hFFFFFFFF00000000 || coll[0] !== 1'b1 || cnt[0] !== 16'd2)
         $display("FAIL coll2: q_b=%h v=%b q_a=%h coll=%b cnt=%0d want ffffffffffffffff 1 ffffffff00000000 1 2",
                  q_b[0], vld_b[0], q_a[0], coll[0], cnt[0]);
      else n_pass++;
      idle(); tick();
      n_total++;
      if (coll[0] !== 1'b0 || cnt[0] !== 16'd2 || q_b[1] !== '1 || q_a[1] !== '1)
         $display("FAIL coll2_after: coll=%b cnt=%0d q_b1=%h q_a1=%h want 0 2 all-ones all-ones",
                  coll[0], cnt[0], q_b[1], q_a[1]);
      else n_pass++;
      tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         drive(1'($urandom_range(0, 3) != 0), ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'h0,
               4'($urandom_range(0, 3)), {$urandom, $urandom},
               1'($urandom_range(0, 3) != 0), ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'h0,
               4'($urandom_range(0, 3)), {$urandom, $urandom});
         tick();
         for (int k = 0; k < 3; k++) begin
            n_total++;
            if (q_a[k] !== e_q[k][0] || vld_a[k] !== e_v[k][0] || q_b[k] !== e_q[k][1] || vld_b[k] !== e_v[k][1]
                || coll[k] !== m_coll || cnt[k] !== 16'(m_cnt) || busy[k] !== 1'b0)
               $display("FAIL rand dut%0d cyc%0d: got %h/%b %h/%b coll=%b cnt=%0d busy=%b want %h/%b %h/%b coll=%b cnt=%0d busy=0",
                        k, c, q_a[k], vld_a[k], q_b[k], vld_b[k], coll[k], cnt[k], busy[k],
                        e_q[k][0], e_v[k][0], e_q[k][1], e_v[k][1], m_coll, m_cnt);
            else n_pass++;
         end
      end
      idle(); tick(); tick();
   endtask

   task automatic test_out_reg_stream();
      for (int t = 1; t <= 18; t++) begin
         if (t <= 16) drive(1, 0, 4'(t - 1), '0, 1, 0, 4'(16 - t), '0); else idle();
         tick();
         n_total++;
         if (vld_a[1] !== 1'(t >= 2 && t <= 17) || vld_b[1] !== 1'(t >= 2 && t <= 17)
             || q_a[1] !== e_q[1][0] || q_b[1] !== e_q[1][1])
            $display("FAIL stream t%0d: v=%b%b q_a=%h q_b=%h want v=%0d q_a=%h q_b=%h",
                     t, vld_a[1], vld_b[1], q_a[1], q_b[1], (t >= 2 && t <= 17), e_q[1][0], e_q[1][1]);
         else n_pass++;
      end
   endtask

   task automatic test_mid_reset();
      int n;
      for (int i = 0; i < 16; i++) begin drive(1, 8'hFF, 4'(i), {$urandom, $urandom} | 64'h1, 0, 0, 0, 0); tick(); end
      drive(1, 8'hFF, 2, '0, 1, 8'hFF, 2, '1); tick();
      for (int i = 0; i < 6; i++) begin
         drive(1, 0, 4'(i), '0, 1, 0, 4'(i + 8), '0);
         rst = (i == 3);
         tick();
      end
      for (int k = 0; k < 3; k++) begin
         n_total++;
         if (vld_a[k] !== e_v[k][0] || vld_b[k] !== e_v[k][1] || cnt[k] !== 16'(m_cnt) || busy[k] !== 1'b1)
            $display("FAIL midrst dut%0d: v=%b%b cnt=%0d busy=%b want v=%b%b cnt=%0d busy=1",
                     k, vld_a[k], vld_b[k], cnt[k], busy[k], e_v[k][0], e_v[k][1], m_cnt);
         else n_pass++;
      end
      idle();
      for (int i = 0; i < 4; i++) tick();
      rst = 1; tick(); rst = 0;
      n = 0;
      while (busy[0] === 1'b1 && n < 40) begin tick(); n++; end
      n_total++;
      if (n != 16) $display("FAIL refill_len: busy lasted %0d cycles, want 16", n); else n_pass++;
      for (int i = 0; i < 16; i++) begin
         drive(1, 0, 4'(i), '0, 1, 0, 4'(i), '0);
         tick();
         n_total++;
         if ({q_a[0], vld_a[0], q_b[0], vld_b[0]} !== {64'h0, 1'b1, 64'h0, 1'b1})
            $display("FAIL refill_read addr%0d: q_a=%h v=%b q_b=%h v=%b, want 0 v=1", i, q_a[0], vld_a[0], q_b[0], vld_b[0]);
         else n_pass++;
      end
      idle(); tick(); tick();
   endtask

   initial begin
      test_reset();
      test_init_reads();
      test_byte_lanes();
      test_rdw();
      test_collision();
      test_random();
      test_out_reg_stream();
      test_mid_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
